// File: rtl/mmio_gpio_bank_pkg.sv
// ============================================================================
// usm_mmio_pkg : register map constants shared by the GPIO bank
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package usm_mmio_pkg;

    localparam int PORT_STRIDE = 32;

    // Byte offsets inside one port's register block
    localparam logic [4:0] OFS_OUT    = 5'h00;
    localparam logic [4:0] OFS_DIR    = 5'h04;
    localparam logic [4:0] OFS_IN     = 5'h08;
    localparam logic [4:0] OFS_RISE   = 5'h0C;
    localparam logic [4:0] OFS_FALL   = 5'h10;
    localparam logic [4:0] OFS_STATUS = 5'h14;
    localparam logic [4:0] OFS_IRQEN  = 5'h18;

endpackage

`default_nettype wire

// File: rtl/gpio_sync_edge.sv
// ============================================================================
// gpio_sync_edge : 2-flop pin synchroniser with rise/fall edge detection
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_sync_edge #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] pin_in,
    output logic [W-1:0] sync_val,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] r_stage1;
    logic [W-1:0] r_stage2;
    logic [W-1:0] r_prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stage1 <= '0;
            r_stage2 <= '0;
            r_prev   <= '0;
        end else begin
            r_stage1 <= pin_in;
            r_stage2 <= r_stage1;
            r_prev   <= r_stage2;
        end
    end

    assign sync_val = r_stage2;
    assign rise     = r_stage2 & ~r_prev;
    assign fall     = ~r_stage2 & r_prev;

endmodule

`default_nettype wire

// File: rtl/mmio_gpio_bank.sv
// ============================================================================
// mmio_gpio_bank : memory-mapped GPIO ports with edge capture and level irq
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_gpio_bank
    import usm_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          N_PORTS   = 2,
    parameter int          PORT_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               bus_addr,
    input  logic [31:0]               bus_wdata,
    input  logic                      bus_we,
    input  logic                      bus_re,
    output logic [31:0]               bus_rdata,
    output logic                      bus_hit,
    input  logic [N_PORTS*PORT_W-1:0] gpio_in,
    output logic [N_PORTS*PORT_W-1:0] gpio_out,
    output logic [N_PORTS*PORT_W-1:0] gpio_oe,
    output logic                      irq
);

    localparam logic [31:0] c_window = 32'(N_PORTS * PORT_STRIDE);

    logic [31:0]               w_rel;
    logic [2:0]                w_port;
    logic [4:0]                w_ofs;
    logic                      w_wr;
    logic [N_PORTS-1:0][31:0]  w_port_rdata;
    logic [N_PORTS-1:0]        w_port_irq;
    logic                      w_unused;

    // Unsigned wrap makes addresses below the base land far outside the window
    assign w_rel    = bus_addr - BASE_ADDR;
    assign bus_hit  = (w_rel < c_window);
    assign w_port   = w_rel[7:5];
    assign w_ofs    = {w_rel[4:2], 2'b00};
    assign w_wr     = bus_we & bus_hit;
    assign w_unused = ^{bus_re, bus_wdata};

    generate
        for (genvar p = 0; p < N_PORTS; p++) begin : g_port
            logic [PORT_W-1:0] r_out;
            logic [PORT_W-1:0] r_dir;
            logic [PORT_W-1:0] r_rise_en;
            logic [PORT_W-1:0] r_fall_en;
            logic [PORT_W-1:0] r_status;
            logic [PORT_W-1:0] r_irq_en;
            logic [PORT_W-1:0] w_sync;
            logic [PORT_W-1:0] w_rise;
            logic [PORT_W-1:0] w_fall;
            logic [PORT_W-1:0] w_wdata;
            logic [PORT_W-1:0] w_w1c;
            logic              w_sel;
            logic [31:0]       w_rd;

            gpio_sync_edge #(.W(PORT_W)) u_sync (
                .clk      (clk),
                .reset    (reset),
                .pin_in   (gpio_in[p*PORT_W +: PORT_W]),
                .sync_val (w_sync),
                .rise     (w_rise),
                .fall     (w_fall)
            );

            assign w_sel   = w_wr && (w_port == 3'(p));
            assign w_wdata = bus_wdata[PORT_W-1:0];
            assign w_w1c   = (w_sel && (w_ofs == OFS_STATUS)) ? w_wdata : '0;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_out     <= '0;
                    r_dir     <= '0;
                    r_rise_en <= '0;
                    r_fall_en <= '0;
                    r_status  <= '0;
                    r_irq_en  <= '0;
                end else begin
                    if (w_sel) begin
                        case (w_ofs)
                            OFS_OUT:   r_out     <= w_wdata;
                            OFS_DIR:   r_dir     <= w_wdata;
                            OFS_RISE:  r_rise_en <= w_wdata;
                            OFS_FALL:  r_fall_en <= w_wdata;
                            OFS_IRQEN: r_irq_en  <= w_wdata;
                            default:   ;
                        endcase
                    end
                    // A fresh edge overrides a clear landing in the same cycle
                    r_status <= (r_status & ~w_w1c)
                              | (w_rise & r_rise_en)
                              | (w_fall & r_fall_en);
                end
            end

            always_comb begin
                w_rd = '0;
                case (w_ofs)
                    OFS_OUT:    w_rd[PORT_W-1:0] = r_out;
                    OFS_DIR:    w_rd[PORT_W-1:0] = r_dir;
                    OFS_IN:     w_rd[PORT_W-1:0] = w_sync;
                    OFS_RISE:   w_rd[PORT_W-1:0] = r_rise_en;
                    OFS_FALL:   w_rd[PORT_W-1:0] = r_fall_en;
                    OFS_STATUS: w_rd[PORT_W-1:0] = r_status;
                    OFS_IRQEN:  w_rd[PORT_W-1:0] = r_irq_en;
                    default:    w_rd = '0;
                endcase
            end

            assign w_port_rdata[p]                = w_rd;
            assign w_port_irq[p]                  = |(r_status & r_irq_en);
            assign gpio_out[p*PORT_W +: PORT_W]   = r_out;
            assign gpio_oe[p*PORT_W +: PORT_W]    = r_dir;
        end
    endgenerate

    always_comb begin
        bus_rdata = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (bus_hit && (w_port == 3'(p))) begin
                bus_rdata = w_port_rdata[p];
            end
        end
    end

    assign irq = |w_port_irq;

    a_no_load_store_overlap : assert property (
        @(posedge clk) disable iff (!reset) !(bus_we && bus_re)
    );

endmodule

`default_nettype wire

// File: tb/tb_mmio_gpio_bank.sv
// ============================================================================
// tb_mmio_gpio_bank : table vectors, directed edge sequences and random traffic
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_gpio_bank;

    localparam int          NP   = 2;
    localparam int          PW   = 8;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_rdata;
    logic        bus_hit;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic [15:0] gpio_oe;
    logic        irq;

    always #5 clk = ~clk;

    mmio_gpio_bank #(.BASE_ADDR(BASE), .N_PORTS(NP), .PORT_W(PW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_rdata (bus_rdata),
        .bus_hit   (bus_hit),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oe   (gpio_oe),
        .irq       (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: register images plus a history of pin samples per edge
    logic [7:0]  m_out[NP], m_dir[NP], m_ren[NP], m_fen[NP], m_st[NP], m_ien[NP];
    logic [15:0] m_h0, m_h1, m_h2;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] rel;
        int          p;
        logic [7:0]  v;
        rel = a - BASE;
        if (rel >= 32'(NP * 32)) return 32'h0;
        p = int'(rel / 32);
        case ((rel % 32) / 4)
            0:       v = m_out[p];
            1:       v = m_dir[p];
            2:       v = m_h1[p*8 +: 8];
            3:       v = m_ren[p];
            4:       v = m_fen[p];
            5:       v = m_st[p];
            6:       v = m_ien[p];
            default: v = 8'h0;
        endcase
        return {24'h0, v};
    endfunction

    function automatic logic m_irq();
        logic r = 1'b0;
        for (int p = 0; p < NP; p++) r |= |(m_st[p] & m_ien[p]);
        return r;
    endfunction

    function automatic void m_tick();
        logic [31:0] rel;
        int          wp, wo;
        if (!reset) begin
            for (int p = 0; p < NP; p++) begin
                m_out[p] = 0; m_dir[p] = 0; m_ren[p] = 0;
                m_fen[p] = 0; m_st[p]  = 0; m_ien[p] = 0;
            end
            m_h0 = 0; m_h1 = 0; m_h2 = 0;
            return;
        end
        rel = bus_addr - BASE;
        wp  = int'(rel / 32);
        wo  = int'((rel % 32) / 4);
        for (int p = 0; p < NP; p++) begin
            logic [7:0] rise, fall, clr, newedge;
            rise    = m_h1[p*8 +: 8] & ~m_h2[p*8 +: 8];
            fall    = ~m_h1[p*8 +: 8] & m_h2[p*8 +: 8];
            newedge = (rise & m_ren[p]) | (fall & m_fen[p]);
            clr     = 8'h0;
            if (bus_we && rel < 32'(NP * 32) && wp == p) begin
                case (wo)
                    0:       m_out[p] = bus_wdata[7:0];
                    1:       m_dir[p] = bus_wdata[7:0];
                    3:       m_ren[p] = bus_wdata[7:0];
                    4:       m_fen[p] = bus_wdata[7:0];
                    5:       clr      = bus_wdata[7:0];
                    6:       m_ien[p] = bus_wdata[7:0];
                    default: ;
                endcase
            end
            m_st[p] = (m_st[p] & ~clr) | newedge;
        end
        m_h2 = m_h1; m_h1 = m_h0; m_h0 = gpio_in;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model_hit",   32'(bus_hit),   32'(m_read(bus_addr) !== 32'hx && (bus_addr - BASE) < 32'(NP*32)));
        chk("model_rdata", bus_rdata,      m_read(bus_addr));
        chk("model_out",   32'(gpio_out),  32'({m_out[1], m_out[0]}));
        chk("model_oe",    32'(gpio_oe),   32'({m_dir[1], m_dir[0]}));
        chk("model_irq",   32'(irq),       32'(m_irq()));
    endtask

    // Inputs are already set at the falling edge; check, cross one rising edge
    task automatic tick();
        #1;
        check_model();
        @(posedge clk);
        m_tick();
        @(negedge clk);
    endtask

    task automatic idle();
        bus_we = 0; bus_re = 0;
        tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_we = 1; bus_re = 0; bus_addr = a; bus_wdata = d;
        tick();
        bus_we = 0;
    endtask

    task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus_we = 0; bus_re = 1; bus_addr = a;
        #1;
        chk(name, bus_rdata, exp);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_hit;
        logic [15:0] exp_out;
        logic [15:0] exp_oe;
    } vec_t;

    vec_t tbl[18];

    initial begin
        tbl[0]  = '{1'b0, 32'h1000, 32'h0,         32'h00, 1'b1, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b0, 32'h1024, 32'h0,         32'h00, 1'b1, 16'h0000, 16'h0000};
        tbl[2]  = '{1'b0, 32'h1034, 32'h0,         32'h00, 1'b1, 16'h0000, 16'h0000};
        tbl[3]  = '{1'b0, 32'h1040, 32'h0,         32'h00, 1'b0, 16'h0000, 16'h0000};
        tbl[4]  = '{1'b0, 32'h103C, 32'h0,         32'h00, 1'b1, 16'h0000, 16'h0000};
        tbl[5]  = '{1'b1, 32'h1020, 32'hA5,        32'h00, 1'b1, 16'h0000, 16'h0000};
        tbl[6]  = '{1'b1, 32'h1024, 32'hFF,        32'h00, 1'b1, 16'hA500, 16'h0000};
        tbl[7]  = '{1'b0, 32'h1020, 32'h0,         32'hA5, 1'b1, 16'hA500, 16'hFF00};
        tbl[8]  = '{1'b0, 32'h1024, 32'h0,         32'hFF, 1'b1, 16'hA500, 16'hFF00};
        tbl[9]  = '{1'b1, 32'h101C, 32'hFFFF,      32'h00, 1'b1, 16'hA500, 16'hFF00};
        tbl[10] = '{1'b0, 32'h101C, 32'h0,         32'h00, 1'b1, 16'hA500, 16'hFF00};
        tbl[11] = '{1'b1, 32'h1008, 32'hFF,        32'h00, 1'b1, 16'hA500, 16'hFF00};
        tbl[12] = '{1'b0, 32'h1008, 32'h0,         32'h00, 1'b1, 16'hA500, 16'hFF00};
        tbl[13] = '{1'b1, 32'h0FFC, 32'hFF,        32'h00, 1'b0, 16'hA500, 16'hFF00};
        tbl[14] = '{1'b0, 32'h1000, 32'h0,         32'h00, 1'b1, 16'hA500, 16'hFF00};
        tbl[15] = '{1'b1, 32'h1000, 32'h1234_5603, 32'h00, 1'b1, 16'hA500, 16'hFF00};
        tbl[16] = '{1'b0, 32'h1001, 32'h0,         32'h03, 1'b1, 16'hA503, 16'hFF00};
        tbl[17] = '{1'b0, 32'h1004, 32'h0,         32'h00, 1'b1, 16'hA503, 16'hFF00};

        reset = 0; bus_we = 0; bus_re = 0; bus_addr = BASE; bus_wdata = 0; gpio_in = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); m_tick(); @(negedge clk);
        end
        reset = 1;
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_oe",  32'(gpio_oe), 32'h0);
        chk("reset_out", 32'(gpio_out), 32'h0);
        for (int p = 0; p < NP; p++)
            for (int o = 0; o < 8; o++)
                peek("reset_reg", BASE + 32'(p*32 + o*4), 32'h0);

        for (int i = 0; i < 18; i++) begin
            bus_we = tbl[i].we; bus_re = ~tbl[i].we;
            bus_addr = tbl[i].addr; bus_wdata = tbl[i].wdata;
            #1;
            chk("tbl_rdata", bus_rdata, tbl[i].exp_rdata);
            chk("tbl_hit",   32'(bus_hit), 32'(tbl[i].exp_hit));
            chk("tbl_out",   32'(gpio_out), 32'(tbl[i].exp_out));
            chk("tbl_oe",    32'(gpio_oe), 32'(tbl[i].exp_oe));
            tick();
        end

        // Rising edge on pin 3 of port 0 through to irq
        wr(32'h100C, 32'h08);
        wr(32'h1018, 32'h08);
        gpio_in[3] = 1'b1;
        idle();
        peek("in_after_E", 32'h1008, 32'h00);
        idle();
        peek("in_after_E1", 32'h1008, 32'h08);
        peek("status_after_E1", 32'h1014, 32'h00);
        chk("irq_after_E1", 32'(irq), 32'h0);
        idle();
        peek("status_after_E2", 32'h1014, 32'h08);
        chk("irq_after_E2", 32'(irq), 32'h1);
        wr(32'h1014, 32'h08);
        peek("status_cleared", 32'h1014, 32'h00);
        chk("irq_cleared", 32'(irq), 32'h0);

        // Falling edge arriving in the same cycle as a clear
        wr(32'h1010, 32'h08);
        gpio_in[3] = 1'b0;
        idle();
        idle();
        wr(32'h1014, 32'h08);
        peek("status_edge_wins", 32'h1014, 32'h08);
        chk("irq_edge_wins", 32'(irq), 32'h1);

        // Disabled edges leave STATUS alone
        wr(32'h1014, 32'h08);
        wr(32'h100C, 32'h00);
        wr(32'h1010, 32'h00);
        gpio_in[3] = 1'b1;
        repeat (3) idle();
        gpio_in[3] = 1'b0;
        repeat (3) idle();
        peek("status_no_en", 32'h1014, 32'h00);

        // Enabling the interrupt over an already-set STATUS bit
        wr(32'h102C, 32'h01);
        gpio_in[8] = 1'b1;
        repeat (3) idle();
        peek("status1_set", 32'h1034, 32'h01);
        chk("irq_before_en", 32'(irq), 32'h0);
        wr(32'h1038, 32'h01);
        chk("irq_after_en", 32'(irq), 32'h1);

        // Reset during a store: reset wins
        reset = 0;
        bus_we = 1; bus_re = 0; bus_addr = 32'h1000; bus_wdata = 32'hFF;
        tick();
        reset = 1; bus_we = 0;
        peek("out_after_reset", 32'h1000, 32'h00);
        chk("gpio_out_after_reset", 32'(gpio_out), 32'h0);
        chk("irq_after_reset", 32'(irq), 32'h0);
        gpio_in = 16'hFFFF;
        repeat (4) idle();
        peek("status0_refill", 32'h1014, 32'h00);
        peek("status1_refill", 32'h1034, 32'h00);
        peek("in0_refill", 32'h1008, 32'hFF);
        idle();

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 3) == 0) gpio_in = 16'($urandom);
            bus_addr  = (($urandom_range(0, 15) == 0) ? BASE - 32'd4 : BASE + 32'($urandom_range(0, 32'h4F)));
            bus_wdata = $urandom;
            bus_we    = ($urandom_range(0, 9) < 4);
            bus_re    = ~bus_we;
            tick();
        end
        reset = 1; bus_we = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
